// File: rtl/din_pkg.sv
// -----------------------------------------------------------------------------
// din_pkg
// Shared constants for the digital-input conditioning stage that feeds the
// SPI stepper core's 16-bit din word.
//   DIN_N          : number of input channels
//   DIN_CW         : debounce counter width (max threshold 2^CW-1 ticks)
//   DIN_THRESH_DEF : default debounce threshold in ticks
//   TICK_DIV       : default tick divider exponent (tick every 2^TICK_DIV clk)
// -----------------------------------------------------------------------------
package din_pkg;

  localparam int DIN_N    = 16;
  localparam int DIN_CW   = 4;
  localparam int TICK_DIV = 6;

  localparam logic [DIN_CW-1:0] DIN_THRESH_DEF = 4'd3;

  typedef logic [DIN_N-1:0] din_word_t;

endpackage : din_pkg

// File: rtl/din_debounce_if.sv
// -----------------------------------------------------------------------------
// din_debounce_if
// Control/input bundle of the din_debounce block.
//   tick   : single-cycle debounce time-base enable
//   raw_in : asynchronous field inputs (one bit per channel)
//   thresh : debounce threshold in ticks, quasi-static
//   snap   : single-cycle snapshot strobe (SPI message start)
// Modports: master drives the bundle, slave (the debouncer) consumes it.
// -----------------------------------------------------------------------------
interface din_debounce_if #(
  parameter int N  = din_pkg::DIN_N,
  parameter int CW = din_pkg::DIN_CW
);

  logic          tick;
  logic [N-1:0]  raw_in;
  logic [CW-1:0] thresh;
  logic          snap;

  modport master (output tick, output raw_in, output thresh, output snap);
  modport slave  (input  tick, input  raw_in, input  thresh, input  snap);

endinterface : din_debounce_if

// File: rtl/din_debounce_ch.sv
// -----------------------------------------------------------------------------
// din_debounce_ch
// One input channel: 2-FF synchroniser, tick-driven debounce counter,
// registered debounced level and sticky change flag.
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   tick_i   : debounce time-base enable
//   raw_i    : asynchronous field input
//   thresh_i : debounce threshold in ticks
//   snap_i   : snapshot strobe; clears the sticky flag (same-cycle accept kept)
//   level_o  : debounced level
//   chg_o    : sticky change flag (pre-clear value is what a snap captures)
// -----------------------------------------------------------------------------
module din_debounce_ch #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          raw_i,
  input  logic [CW-1:0] thresh_i,
  input  logic          snap_i,
  output logic          level_o,
  output logic          chg_o
);

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          chg_q;
  logic          chg_d;
  logic          accept_s;

  // Debounce filter next-state and sticky change flag update.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    accept_s = 1'b0;
    if (s2_q == level_q) begin
      // Input agrees with the level: any bounce in progress is abandoned.
      cnt_d = {CW{1'b0}};
    end else if (tick_i) begin
      // >= rather than == so a lowered threshold accepts at once and cnt
      // can never run past the maximum threshold.
      if (cnt_q >= thresh_i) begin
        level_d  = s2_q;
        cnt_d    = {CW{1'b0}};
        accept_s = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A snap hands the old flag to the snapshot register and restarts the
    // accumulation with whatever is accepted in that same cycle.
    if (snap_i) begin
      chg_d = accept_s;
    end else begin
      chg_d = chg_q | accept_s;
    end
  end

  // Synchroniser, counter, level and change flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      chg_q   <= chg_d;
    end
  end

  assign level_o = level_q;
  assign chg_o   = chg_q;

endmodule : din_debounce_ch

// File: rtl/din_debounce.sv
// -----------------------------------------------------------------------------
// din_debounce
// Synchronises and debounces N field inputs on a shared slow tick, keeps a
// sticky per-channel change mask, and freezes a coherent level word and
// change mask on every snapshot strobe for the SPI core to shift out.
//   clk          : system clock
//   rst          : synchronous reset, active-high
//   bus          : slave side of din_debounce_if (tick, raw_in, thresh, snap)
//   level_o      : live debounced level per channel
//   level_snap_o : debounced levels frozen at the last snap
//   chg_snap_o   : change mask frozen at the last snap
//   any_chg_o    : registered OR of the live sticky change mask
// -----------------------------------------------------------------------------
module din_debounce
  import din_pkg::*;
#(
  parameter int N  = DIN_N,
  parameter int CW = DIN_CW
) (
  input  logic          clk,
  input  logic          rst,
  din_debounce_if.slave bus,
  output logic [N-1:0]  level_o,
  output logic [N-1:0]  level_snap_o,
  output logic [N-1:0]  chg_snap_o,
  output logic          any_chg_o
);

  logic [N-1:0] level_s;
  logic [N-1:0] chg_s;
  logic [N-1:0] level_snap_q;
  logic [N-1:0] level_snap_d;
  logic [N-1:0] chg_snap_q;
  logic [N-1:0] chg_snap_d;
  logic         any_chg_q;
  logic         any_chg_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    din_debounce_ch #(
      .CW (CW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (bus.tick),
      .raw_i    (bus.raw_in[gi]),
      .thresh_i (bus.thresh),
      .snap_i   (bus.snap),
      .level_o  (level_s[gi]),
      .chg_o    (chg_s[gi])
    );
  end

  // Snapshot capture: registered (pre-update) level and change mask.
  always_comb begin
    if (bus.snap) begin
      level_snap_d = level_s;
      chg_snap_d   = chg_s;
    end else begin
      level_snap_d = level_snap_q;
      chg_snap_d   = chg_snap_q;
    end
    any_chg_d = |chg_s;
  end

  // Snapshot and summary-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_snap_q <= {N{1'b0}};
      chg_snap_q   <= {N{1'b0}};
      any_chg_q    <= 1'b0;
    end else begin
      level_snap_q <= level_snap_d;
      chg_snap_q   <= chg_snap_d;
      any_chg_q    <= any_chg_d;
    end
  end

  assign level_o      = level_s;
  assign level_snap_o = level_snap_q;
  assign chg_snap_o   = chg_snap_q;
  assign any_chg_o    = any_chg_q;

endmodule : din_debounce

// File: tb/tb_din_debounce.sv
// -----------------------------------------------------------------------------
// tb_din_debounce
// Directed-vector bench for din_debounce. Stimulus pushes expected level_o
// transitions (value + tick index at which they appear) and expected snapshot
// words into queues; a monitor pops and compares whenever level_o changes or
// a snap has been applied.
// -----------------------------------------------------------------------------
module tb_din_debounce;
  import din_pkg::*;

  localparam int TICKP = 1 << TICK_DIV;

  typedef struct {
    int        t;
    din_word_t v;
  } lvl_exp_t;

  typedef struct {
    din_word_t l;
    din_word_t c;
  } snp_exp_t;

  logic      clk = 1'b0;
  logic      rst;
  din_word_t level_o;
  din_word_t level_snap_o;
  din_word_t chg_snap_o;
  logic      any_chg_o;

  int  total    = 0;
  int  bad      = 0;
  int  tick_cnt = 0;
  bit  mon_en   = 1'b0;

  lvl_exp_t lq[$];
  snp_exp_t sq[$];

  din_debounce_if #(.N(DIN_N), .CW(DIN_CW)) bus ();

  din_debounce #(
    .N  (DIN_N),
    .CW (DIN_CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .level_o      (level_o),
    .level_snap_o (level_snap_o),
    .chg_snap_o   (chg_snap_o),
    .any_chg_o    (any_chg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_level"}, 32'(level_o), 32'd0);
    chk({nm, "_lsnap"}, 32'(level_snap_o), 32'd0);
    chk({nm, "_csnap"}, 32'(chg_snap_o), 32'd0);
    chk({nm, "_any"}, 32'(any_chg_o), 32'd0);
  endtask

  // Run n tick periods; each ends just after the tick edge has been applied.
  task automatic wait_ticks(input int n, input bit snap_last = 1'b0);
    for (int k = 0; k < n; k++) begin
      repeat (TICKP - 1) @(negedge clk);
      bus.tick = 1'b1;
      if (k == n - 1) bus.snap = snap_last;
      tick_cnt++;
      @(negedge clk);
      bus.tick = 1'b0;
      bus.snap = 1'b0;
    end
  endtask

  task automatic push_lvl(input int t, input din_word_t v);
    lvl_exp_t e;
    e.t = t;
    e.v = v;
    lq.push_back(e);
  endtask

  task automatic push_snp(input din_word_t l, input din_word_t c);
    snp_exp_t e;
    e.l = l;
    e.c = c;
    sq.push_back(e);
  endtask

  task automatic do_snap(input din_word_t l, input din_word_t c);
    push_snp(l, c);
    bus.snap = 1'b1;
    @(negedge clk);
    bus.snap = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compares level_o transitions and snapshot outputs to the queues.
  initial begin : monitor
    logic      sn;
    din_word_t prev;
    lvl_exp_t  le;
    snp_exp_t  se;
    prev = '0;
    forever begin
      @(posedge clk);
      sn = bus.snap;
      #1;
      if (mon_en) begin
        if (level_o !== prev) begin
          if (lq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL lvl_unexpected act=%h req=%h", level_o, prev);
          end else begin
            le = lq.pop_front();
            chk("lvl_val", 32'(level_o), 32'(le.v));
            chk("lvl_tick", tick_cnt, le.t);
          end
        end
        if (sn) begin
          if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL snap_unexpected act=%h req=none", chg_snap_o);
          end else begin
            se = sq.pop_front();
            chk("snap_level", 32'(level_snap_o), 32'(se.l));
            chk("snap_chg", 32'(chg_snap_o), 32'(se.c));
          end
        end
      end
      prev = level_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst         = 1'b1;
    bus.tick    = 1'b0;
    bus.snap    = 1'b0;
    bus.raw_in  = 16'hFFFF;
    bus.thresh  = DIN_THRESH_DEF;

    // Reset held 3 clk with all inputs high.
    repeat (3) begin
      @(negedge clk);
      chk_zero("rst");
    end
    rst = 1'b0;
    @(negedge clk);
    chk_zero("rst_after");
    mon_en = 1'b1;

    // Reset release: all channels accept on tick thresh+1.
    push_lvl(tick_cnt + 4, 16'hFFFF);
    wait_ticks(4);
    do_snap(16'hFFFF, 16'hFFFF);

    // Back to all-low baseline.
    bus.raw_in = 16'h0000;
    push_lvl(tick_cnt + 4, 16'h0000);
    wait_ticks(4);
    do_snap(16'h0000, 16'hFFFF);
    chk("any_after_snap0", 32'(any_chg_o), 32'd0);

    // Clean edge on channel 0.
    bus.raw_in = 16'h0001;
    push_lvl(tick_cnt + 4, 16'h0001);
    wait_ticks(4);
    chk("any_same_clk", 32'(any_chg_o), 32'd0);
    @(negedge clk);
    chk("any_next_clk", 32'(any_chg_o), 32'd1);
    do_snap(16'h0001, 16'h0001);
    chk("any_cleared", 32'(any_chg_o), 32'd0);

    // Bounce rejection on channel 5.
    for (int r = 0; r < 10; r++) begin
      bus.raw_in = 16'h0021;
      wait_ticks(2);
      bus.raw_in = 16'h0001;
      wait_ticks(1);
    end
    chk("bounce_level", 32'(level_o), 32'h0001);
    do_snap(16'h0001, 16'h0000);

    // Short pulse on channel 9 between snaps.
    bus.raw_in = 16'h0201;
    push_lvl(tick_cnt + 4, 16'h0201);
    wait_ticks(5);
    bus.raw_in = 16'h0001;
    push_lvl(tick_cnt + 4, 16'h0001);
    wait_ticks(5);
    do_snap(16'h0001, 16'h0200);

    // Snap coinciding with the accepting tick of channel 2.
    bus.raw_in = 16'h0005;
    push_lvl(tick_cnt + 4, 16'h0005);
    wait_ticks(3);
    push_snp(16'h0001, 16'h0000);
    wait_ticks(1, 1'b1);
    @(negedge clk);
    do_snap(16'h0005, 16'h0004);

    // thresh = 0: accept on the first tick.
    bus.thresh = 4'd0;
    bus.raw_in = 16'h000D;
    push_lvl(tick_cnt + 1, 16'h000D);
    wait_ticks(1);

    // thresh = 15: accept on the 16th tick.
    bus.thresh = 4'd15;
    bus.raw_in = 16'h0005;
    push_lvl(tick_cnt + 16, 16'h0005);
    wait_ticks(16);

    // Lower thresh 15 -> 2 with cnt = 7: accept on the next tick.
    bus.raw_in = 16'h0015;
    wait_ticks(7);
    bus.thresh = 4'd2;
    push_lvl(tick_cnt + 1, 16'h0015);
    wait_ticks(1);
    do_snap(16'h0015, 16'h0018);

    // Mid-count reset on channel 6: count discarded, nothing flagged.
    bus.thresh = 4'd3;
    bus.raw_in = 16'h0055;
    wait_ticks(2);
    push_lvl(tick_cnt, 16'h0000);
    rst = 1'b1;
    bus.raw_in = 16'h0040;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("midrst_after");
    push_lvl(tick_cnt + 4, 16'h0040);
    wait_ticks(3);
    chk("midrst_hold", 32'(level_o), 32'h0000);
    wait_ticks(1);
    do_snap(16'h0040, 16'h0040);

    repeat (4) @(negedge clk);
    chk("lvl_queue_empty", lq.size(), 0);
    chk("snap_queue_empty", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_din_debounce

// File: doc/din_debounce.md
Name: din_debounce

Overview:
- Input-conditioning stage directly upstream of the SPI stepper core's 16-bit digital input word (din).
- Synchronises 16 raw field inputs (limit/home switches, e-stop, probe) and debounces each one on a shared slow tick.
- Keeps a sticky per-channel change mask so that a short input event between two SPI frames still reaches the host.
- On each snapshot strobe (asserted at SPI message start), freezes a coherent level word and change mask for the SPI core to shift out.

Parameters:
N, 16, number of input channels
CW, 4, debounce counter width in bits; sets the maximum threshold to 2^CW-1 ticks

Ports:
clk  input  1  system clock (PLL output)
rst  input  1  synchronous reset, active-high
tick  input  1  single-cycle debounce time-base enable (e.g. every 64 clk, from the shared divider)
raw_in  input  N  asynchronous field inputs
thresh  input  CW  debounce threshold in ticks; host-written, quasi-static
snap  input  1  single-cycle snapshot strobe
level_o  output  N  live debounced level per channel
level_snap_o  output  N  debounced levels frozen at the last snap
chg_snap_o  output  N  change mask frozen at the last snap
any_chg_o  output  1  OR of the live sticky change accumulator

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high. On rst all flops clear: sync stages, counters, level_o, chg accumulator, level_snap_o, chg_snap_o and any_chg_o are all 0. Reset asserted mid-debounce discards the count.
- Synchroniser: 2-FF chain per channel (s1 then s2); s2 is the only value the filter sees. raw_in is never used combinationally.
- Per-channel filter, evaluated every clk:
  - s2 == level: cnt <= 0. An in-progress bounce is abandoned.
  - s2 != level and tick == 1 and cnt >= thresh: level <= s2, cnt <= 0, chg_acc[i] <= 1.
  - s2 != level and tick == 1 and cnt < thresh: cnt <= cnt + 1.
  - s2 != level and tick == 0: hold.
- Acceptance uses >=, so cnt never wraps. If thresh is lowered below the current cnt, the channel accepts on the next tick. thresh = 0 accepts on the first tick after the mismatch.
- Latency from raw_in edge to level_o: 2 clk, then (thresh+1) ticks. The acceptance tick is included.
- level_o is registered and updates one clk after the accepting tick cycle.
- Snapshot, on snap == 1:
  - level_snap_o <= level_o (pre-update value in that cycle).
  - chg_snap_o <= chg_acc (pre-update value).
  - chg_acc <= 0, then OR in any acceptance occurring in that same cycle, so no event is lost or double-counted.
- snap and tick may coincide. Back-to-back snap pulses are legal; the second captures only the changes that occurred between them.
- Snapshot outputs are stable between snaps. The SPI core samples them at any byte slot without tearing.
- any_chg_o = |chg_acc, registered. It is available for a future interrupt/LED.

Decomposition:
- Shared package din_pkg holds: DIN_N = 16, DIN_CW = 4, the default threshold constant DIN_THRESH_DEF = 3, and the default tick divider exponent TICK_DIV = 6.
- One sub-module is natural: din_debounce_ch (sync + counter + level + chg flag for one bit, parameter CW). The top generates N instances and implements the snapshot registers and any_chg OR-reduce.

Test Plan:
- Reset: drive rst 3 clk with raw_in = 16'hFFFF -> all outputs 0 during reset and on the first clk after; level_o then reaches FFFF only after 2 clk + (thresh+1) ticks.
- Clean edge, thresh = 3, tick every 64 clk: raw_in[0] 0->1 -> level_o[0] rises exactly on the 4th tick after s2 goes high; any_chg_o = 1 one clk later. snap then gives chg_snap_o = 16'h0001, level_snap_o[0] = 1, any_chg_o = 0.
- Bounce rejection, thresh = 3: raw_in[5] toggles high for 2 ticks then low, repeated 10 times -> level_o[5] stays 0 and chg_snap_o[5] = 0 at the next snap.
- Short pulse between snaps: raw_in[9] high for 5 ticks, then low for 5 ticks, with no snap in between -> level_o[9] returns to 0. The following snap yields chg_snap_o[9] = 1 and level_snap_o[9] = 0.
- Simultaneous snap and accept: align snap with the accepting tick for channel 2 -> that snap's chg_snap_o[2] = 0, level_snap_o[2] = old value. The next snap gives chg_snap_o[2] = 1, level_snap_o[2] = new value.
- thresh edge cases:
  - thresh = 0: accept on the first tick.
  - thresh = 15: accept on the 16th tick.
  - Lowering thresh from 15 to 2 while cnt = 7: accept on the next tick.
  - Mid-count rst: cnt and level clear, and no chg is flagged.
